// File: rtl/register_file_nr_if.sv
// Register-file bus: one write port plus NUM_RD packed read ports.
interface register_file_nr_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 3
);
    logic                       we;
    logic [ADDR_W-1:0]          wa;
    logic [DATA_W-1:0]          wd;
    logic [NUM_RD*ADDR_W-1:0]   ra;
    logic [NUM_RD*DATA_W-1:0]   rd;

    modport master (output we, wa, wd, ra, input rd);
    modport slave  (input we, wa, wd, ra, output rd);
endinterface

// File: rtl/register_file_nr.sv
// GPR bank: single write port, NUM_RD read ports, optional zero register,
// write-to-read bypass and registered-read mode.
module register_file_nr #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 3,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          READ_REG = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    register_file_nr_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     wvalid;
    logic [NUM_RD*DATA_W-1:0] src;

    // Reset wins over a pending write; writes to r0 vanish when it is hardwired.
    assign wvalid = bus.we & ~reset & ~(ZERO_REG & (bus.wa == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (wvalid) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // Per-port source: zero register beats bypass, bypass beats storage.
    always_comb begin
        src = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (ZERO_REG && (bus.ra[i*ADDR_W +: ADDR_W] == '0)) begin
                src[i*DATA_W +: DATA_W] = '0;
            end else if (BYPASS && wvalid && (bus.wa == bus.ra[i*ADDR_W +: ADDR_W])) begin
                src[i*DATA_W +: DATA_W] = bus.wd;
            end else begin
                src[i*DATA_W +: DATA_W] = mem[bus.ra[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    if (READ_REG) begin : g_reg
        logic [NUM_RD*DATA_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= src;
            end
        end

        assign bus.rd = rd_q;
    end else begin : g_comb
        assign bus.rd = src;
    end
endmodule

// File: tb/tb_register_file_nr.sv
// Drives a combinational/bypass/zero-reg instance and a registered/no-bypass/no-zero
// instance with identical stimulus; a monitor checks both against queued expectations.
module tb_register_file_nr;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 3;
    localparam int unsigned DEPTH = 32;

    typedef logic [DW-1:0] word_t;
    typedef word_t mem_t [DEPTH];
    typedef struct {
        int    cyc;
        int    dut;
        int    port;
        word_t exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    register_file_nr_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_a ();
    register_file_nr_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();

    register_file_nr #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
                       .ZERO_REG(1'b1), .BYPASS(1'b1), .READ_REG(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));

    register_file_nr #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
                       .ZERO_REG(1'b0), .BYPASS(1'b0), .READ_REG(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    mem_t mem_a;
    mem_t mem_b;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic word_t model(input mem_t m, input bit zr, input bit bp, input bit rst,
                                    input bit w, input logic [AW-1:0] wa, input word_t wd,
                                    input logic [AW-1:0] ra);
        bit wv;
        wv = w && !rst && !(zr && wa == '0);
        if (zr && ra == '0) return '0;
        if (bp && wv && wa == ra) return wd;
        return m[ra];
    endfunction

    task automatic step(input bit rst, input bit w, input logic [AW-1:0] wa, input word_t wd,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input bit chk);
        logic [AW-1:0] ra [NR];
        exp_t e;
        ra[0] = r0; ra[1] = r1; ra[2] = r2;
        @(posedge clk);
        #1;
        reset = rst;
        bus_a.we = w; bus_a.wa = wa; bus_a.wd = wd; bus_a.ra = {r2, r1, r0};
        bus_b.we = w; bus_b.wa = wa; bus_b.wd = wd; bus_b.ra = {r2, r1, r0};
        if (chk) begin
            for (int p = 0; p < int'(NR); p++) begin
                e.cyc = cyc; e.dut = 0; e.port = p;
                e.exp = model(mem_a, 1'b1, 1'b1, rst, w, wa, wd, ra[p]);
                q.push_back(e);
                e.cyc = cyc + 1; e.dut = 1;
                e.exp = rst ? '0 : model(mem_b, 1'b0, 1'b0, rst, w, wa, wd, ra[p]);
                q.push_back(e);
            end
        end
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a[i] = '0;
                mem_b[i] = '0;
            end
        end else if (w) begin
            if (wa != '0) mem_a[wa] = wd;
            mem_b[wa] = wd;
        end
    endtask

    // Monitor: every cycle, retire all expectations due in this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                word_t act;
                act = (q[i].dut == 0) ? bus_a.rd[q[i].port*DW +: DW]
                                      : bus_b.rd[q[i].port*DW +: DW];
                n_chk++;
                if (act === q[i].exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL rd dut%0d port%0d cyc%0d: got %h expected %h",
                             q[i].dut, q[i].port, cyc, act, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        bus_a.we = 1'b0; bus_a.wa = '0; bus_a.wd = '0; bus_a.ra = '0;
        bus_b.we = 1'b0; bus_b.wa = '0; bus_b.wd = '0; bus_b.ra = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_a[i] = 'x;
            mem_b[i] = 'x;
        end
        step(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Every address reads zero after reset.
        for (int a = 0; a < int'(DEPTH); a++) begin
            step(1'b0, 1'b0, 5'd0, '0, 5'(a), 5'(a), 5'(31 - a), 1'b1);
        end

        // Plain write then read on several ports.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 5'd3, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5, 5'd6, 1'b1);

        // Write to r0, checked in the write cycle and after.
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd5, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd5, 5'd0, 1'b1);

        // Same-cycle write-to-read on port 1.
        step(1'b0, 1'b1, 5'd7, 32'h11110000, 5'd0, 5'd1, 5'd2, 1'b1);
        step(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd5, 5'd7, 5'd7, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd7, 5'd0, 1'b1);

        // Registered read follows the address one edge later.
        step(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd1, 5'd1, 5'd1, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd4, 5'd5, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd3, 5'd7, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd0, 5'd3, 1'b1);

        // Reset wins over a simultaneous write.
        step(1'b0, 1'b1, 5'd9, 32'h55, 5'd9, 5'd0, 5'd1, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd9, 5'd9, 1'b1);
        step(1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd9, 5'd3, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd3, 5'd5, 1'b1);

        // Random traffic concentrated on a few addresses to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] r [NR];
            wa = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            for (int p = 0; p < int'(NR); p++) begin
                r[p] = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, wa, $urandom,
                 r[0], r[1], r[2], 1'b1);
        end

        step(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
